// File: rtl/tlb_mh_pkg.sv
// Shared types and constants for the TLB miss handler.
//   state_e        : controller FSM states
//   PTE layout     : valid in bit 0, physical page number in [31:12]
//   pte_addr()     : byte address of the PTE for a virtual address
package tlb_mh_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK_REQ,
    S_WALK_WAIT,
    S_FILL,
    S_RESP
  } state_e;

  localparam int PAGE_OFFSET_W = 12;
  localparam int PTE_SIZE_LOG2 = 2;
  localparam int PTE_VALID_BIT = 0;
  localparam int PTE_PPAGE_MSB = 31;
  localparam int PTE_PPAGE_LSB = PAGE_OFFSET_W;
  localparam int PPAGE_W       = PTE_PPAGE_MSB - PTE_PPAGE_LSB + 1;

  // Linear table: one 4-byte PTE per virtual page; the sum wraps at 2^32.
  function automatic logic [31:0] pte_addr(input logic [31:0] base,
                                           input logic [31:0] va);
    logic [31:0] w_off;
    w_off = 32'(va[31:PAGE_OFFSET_W]) << PTE_SIZE_LOG2;
    return base + w_off;
  endfunction

endpackage

// File: rtl/tlb_walk_timer.sv
// Page-walk timeout timer (built only with TLB_MH_TIMEOUT_EN).
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : reload on the cycle before the walk starts
//   i_run        : walk in progress (WALK_REQ or WALK_WAIT)
//   o_expired    : the walk has spent TIMEOUT_CYCLES cycles without a response
module tlb_walk_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Down-counter: holds TIMEOUT_CYCLES-1 in the first walk cycle, so the
  // terminal count is seen in the TIMEOUT_CYCLES-th walk cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/tlb_miss_handler.sv
// TLB miss handler: queries the TLB, walks a single-level linear page table
// on a miss, fills the TLB and returns the physical address or a fault.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_*                             : translation request (ready only in IDLE)
//   resp_*                            : result; paddr/fault zero unless resp_valid
//   tlb_query_*, tlb_hit, tlb_paddr   : TLB lookup port (combinational hit)
//   mmu_update_valid, mmu_vaddr/paddr : one-cycle TLB fill
//   mem_req_*, mem_rsp_*              : PTE read port
// Optional: define TLB_MH_TIMEOUT_EN to abort walks after TIMEOUT_CYCLES.
//
// state       | meaning
// ------------+--------------------------------------------
// S_IDLE      | waiting for a request
// S_LOOKUP    | querying the TLB with the latched vaddr
// S_WALK_REQ  | issuing the PTE read, held until accepted
// S_WALK_WAIT | waiting for the PTE data
// S_FILL      | writing the valid PTE into the TLB
// S_RESP      | presenting the result until accepted
module tlb_miss_handler
  import tlb_mh_pkg::*;
#(
  parameter logic [31:0] PT_BASE        = 32'h0010_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic        resp_fault,
  output logic        tlb_query_valid,
  output logic [31:0] tlb_query_vaddr,
  input  logic        tlb_hit,
  input  logic [31:0] tlb_paddr,
  output logic        mmu_update_valid,
  output logic [31:0] mmu_vaddr,
  output logic [31:0] mmu_paddr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  state_e             r_state;
  state_e             w_next;
  logic [31:0]        r_va;
  logic [PPAGE_W-1:0] r_ppage;
  logic [31:0]        r_paddr;
  logic               r_fault;
  logic               w_timeout;
  logic               w_pte_valid;

  assign w_pte_valid = mem_rsp_data[PTE_VALID_BIT];

`ifdef TLB_MH_TIMEOUT_EN
  logic w_timer_load;
  logic w_timer_run;

  assign w_timer_load = (r_state == S_LOOKUP) && !tlb_hit;
  assign w_timer_run  = (r_state == S_WALK_REQ) || (r_state == S_WALK_WAIT);

  tlb_walk_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_timer_load),
    .i_run     (w_timer_run),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
`endif

  // PTE attribute bits [11:1] carry nothing this handler uses.
  logic w_unused_pte;
  assign w_unused_pte = ^mem_rsp_data[PTE_PPAGE_LSB-1:PTE_VALID_BIT+1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_paddr       = '0;
    resp_fault       = 1'b0;
    tlb_query_valid  = 1'b0;
    tlb_query_vaddr  = '0;
    mmu_update_valid = 1'b0;
    mmu_vaddr        = '0;
    mmu_paddr        = '0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        tlb_query_valid = 1'b1;
        tlb_query_vaddr = r_va;
        w_next          = tlb_hit ? S_RESP : S_WALK_REQ;
      end
      S_WALK_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = pte_addr(PT_BASE, r_va);
        if (w_timeout)          w_next = S_RESP;
        else if (mem_req_ready) w_next = S_WALK_WAIT;
      end
      S_WALK_WAIT: begin
        // A response landing on the timeout cycle takes priority.
        if (mem_rsp_valid) w_next = w_pte_valid ? S_FILL : S_RESP;
        else if (w_timeout) w_next = S_RESP;
      end
      S_FILL: begin
        mmu_update_valid = 1'b1;
        mmu_vaddr        = r_va;
        mmu_paddr        = {r_ppage, {PAGE_OFFSET_W{1'b0}}};
        w_next           = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_paddr = r_paddr;
        resp_fault = r_fault;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_va    <= '0;
      r_ppage <= '0;
      r_paddr <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) r_va <= req_vaddr;
        S_LOOKUP: begin
          if (tlb_hit) begin
            r_paddr <= tlb_paddr;
            r_fault <= 1'b0;
          end
        end
        S_WALK_REQ: begin
          if (w_timeout) begin
            r_paddr <= '0;
            r_fault <= 1'b1;
          end
        end
        S_WALK_WAIT: begin
          if (mem_rsp_valid) begin
            r_ppage <= mem_rsp_data[PTE_PPAGE_MSB:PTE_PPAGE_LSB];
            if (!w_pte_valid) begin
              r_paddr <= '0;
              r_fault <= 1'b1;
            end
          end else if (w_timeout) begin
            r_paddr <= '0;
            r_fault <= 1'b1;
          end
        end
        S_FILL: begin
          r_paddr <= {r_ppage, r_va[PAGE_OFFSET_W-1:0]};
          r_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_miss_handler.sv
module tb_tlb_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_paddr;
  logic        tlb_query_valid, tlb_hit;
  logic [31:0] tlb_query_vaddr, tlb_paddr;
  logic        mmu_update_valid;
  logic [31:0] mmu_vaddr, mmu_paddr;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_rsp_data;

  always #5 clk = ~clk;

  tlb_miss_handler #(
    .PT_BASE        (32'h0010_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_vaddr        (req_vaddr),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_paddr       (resp_paddr),
    .resp_fault       (resp_fault),
    .tlb_query_valid  (tlb_query_valid),
    .tlb_query_vaddr  (tlb_query_vaddr),
    .tlb_hit          (tlb_hit),
    .tlb_paddr        (tlb_paddr),
    .mmu_update_valid (mmu_update_valid),
    .mmu_vaddr        (mmu_vaddr),
    .mmu_paddr        (mmu_paddr),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed { logic [31:0] paddr; logic fault; } resp_t;
  typedef struct packed { logic [31:0] va; logic [31:0] pa; } fill_t;
  resp_t       exp_resp[$];
  logic [31:0] exp_mem[$];
  fill_t       exp_fill[$];
  resp_t       mon_r;
  fill_t       mon_f;
  logic [31:0] mon_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Small direct-mapped TLB model (4 entries indexed by vpn[1:0]).
  logic        m_vld [4];
  logic [19:0] m_vpn [4];
  logic [19:0] m_ppn [4];
  logic        tb_flush, tb_pre_en;
  logic [19:0] tb_pre_vpn, tb_pre_ppn;
  logic [1:0]  q_idx;

  assign q_idx     = tlb_query_vaddr[13:12];
  assign tlb_hit   = tlb_query_valid && m_vld[q_idx] && (m_vpn[q_idx] == tlb_query_vaddr[31:12]);
  assign tlb_paddr = {m_ppn[q_idx], tlb_query_vaddr[11:0]};

  always @(posedge clk) begin
    if (tb_flush) begin
      for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
    end else if (tb_pre_en) begin
      m_vld[tb_pre_vpn[1:0]] <= 1'b1;
      m_vpn[tb_pre_vpn[1:0]] <= tb_pre_vpn;
      m_ppn[tb_pre_vpn[1:0]] <= tb_pre_ppn;
    end else if (mmu_update_valid) begin
      m_vld[mmu_vaddr[13:12]] <= 1'b1;
      m_vpn[mmu_vaddr[13:12]] <= mmu_vaddr[31:12];
      m_ppn[mmu_vaddr[13:12]] <= mmu_paddr[31:12];
    end
  end

  // Monitor / scoreboard
  logic        p_mem_stall = 1'b0, p_resp_stall = 1'b0, p_fault;
  logic [31:0] p_addr, p_paddr;

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          mon_r = exp_resp.pop_front();
          chk("resp_paddr", resp_paddr, mon_r.paddr);
          chk("resp_fault", resp_fault, mon_r.fault);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_mem.size() == 0) chk("mem_req_unexpected", 1, 0);
        else begin
          mon_a = exp_mem.pop_front();
          chk("mem_req_addr", mem_req_addr, mon_a);
        end
      end
      if (mmu_update_valid) begin
        if (exp_fill.size() == 0) chk("fill_unexpected", 1, 0);
        else begin
          mon_f = exp_fill.pop_front();
          chk("mmu_vaddr", mmu_vaddr, mon_f.va);
          chk("mmu_paddr", mmu_paddr, mon_f.pa);
        end
      end
      if (p_mem_stall) begin
        chk("mem_req_hold_valid", mem_req_valid, 1);
        chk("mem_req_hold_addr", mem_req_addr, p_addr);
      end
      if (p_resp_stall)
        chk("resp_hold", {resp_valid, resp_fault, resp_paddr}, {1'b1, p_fault, p_paddr});
      if (resp_valid || mem_req_valid || mmu_update_valid || tlb_query_valid)
        chk("req_ready_busy", req_ready, 0);
      p_mem_stall  <= mem_req_valid && !mem_req_ready;
      p_addr       <= mem_req_addr;
      p_resp_stall <= resp_valid && !resp_ready;
      p_paddr      <= resp_paddr;
      p_fault      <= resp_fault;
    end else begin
      p_mem_stall  <= 1'b0;
      p_resp_stall <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_ctrl"}, {resp_valid, resp_fault, tlb_query_valid, mmu_update_valid, mem_req_valid}, 0);
    chk({tag, "_data"}, |{resp_paddr, tlb_query_vaddr, mmu_vaddr, mmu_paddr, mem_req_addr}, 0);
  endtask

  // Handshake at the next edge; returns in the LOOKUP cycle.
  task automatic send_req(input logic [31:0] va);
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_vaddr = va;
    step();
    req_valid = 1'b0;
    req_vaddr = '0;
    chk("lookup_valid", tlb_query_valid, 1);
    chk("lookup_vaddr", tlb_query_vaddr, va);
  endtask

  task automatic hit_req(input logic [31:0] va, input logic [31:0] pa);
    exp_resp.push_back({pa, 1'b0});
    send_req(va);
    chk("hit_no_memreq_c1", mem_req_valid, 0);
    step();
    chk("hit_resp_c2", resp_valid, 1);
    chk("hit_no_memreq_c2", mem_req_valid, 0);
    step();
    chk("hit_idle", req_ready, 1);
  endtask

  // Called in the LOOKUP cycle of a missing request.
  task automatic do_walk(input logic [31:0] pte, input int ready_dly,
                         input int rsp_dly, input int resp_hold);
    step();
    chk("walk_memreq_c2", mem_req_valid, 1);
    repeat (ready_dly) step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("walk_wait_no_req", mem_req_valid, 0);
    repeat (rsp_dly) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = pte;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pte[0]) begin
      chk("fill_pulse", mmu_update_valid, 1);
      chk("fill_no_resp", resp_valid, 0);
      step();
      chk("fill_one_cycle", mmu_update_valid, 0);
    end
    chk("resp_after_walk", resp_valid, 1);
    if (resp_hold > 0) begin
      repeat (resp_hold) step();
      chk("resp_still_held", resp_valid, 1);
      resp_ready = 1'b1;
    end
    step();
    chk("idle_after_resp", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_vaddr = '0; resp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    tb_flush = 1'b1; tb_pre_en = 1'b0; tb_pre_vpn = '0; tb_pre_ppn = '0;
    step();
    tb_flush = 1'b0;
    step();
    chk_reset_outs("reset");
    reset = 1'b0;
    step();

    // Preloaded hit
    tb_pre_en = 1'b1; tb_pre_vpn = 20'h00005; tb_pre_ppn = 20'h00087;
    step();
    tb_pre_en = 1'b0;
    hit_req(32'h0000_5ABC, 32'h0008_7ABC);
    tb_flush = 1'b1;
    step();
    tb_flush = 1'b0;

    // Miss with valid PTE, then immediate repeat hits
    exp_mem.push_back(32'h0010_0014);
    exp_fill.push_back({32'h0000_5ABC, 32'h0008_7000});
    exp_resp.push_back({32'h0008_7ABC, 1'b0});
    send_req(32'h0000_5ABC);
    do_walk(32'h0008_7001, 0, 1, 0);
    hit_req(32'h0000_5ABC, 32'h0008_7ABC);

    // Invalid PTE: fault, no fill
    exp_mem.push_back(32'h0010_0024);
    exp_resp.push_back({32'h0000_0000, 1'b1});
    send_req(32'h0000_9123);
    do_walk(32'h0008_7000, 0, 2, 0);

    // Backpressure on both ports; attribute bits in the PTE are ignored
    exp_mem.push_back(32'h0014_8D14);
    exp_fill.push_back({32'h1234_5678, 32'hABCD_E000});
    exp_resp.push_back({32'hABCD_E678, 1'b0});
    resp_ready = 1'b0;
    send_req(32'h1234_5678);
    do_walk(32'hABCD_E003, 5, 0, 3);

    // Reset during WALK_WAIT, then a stale response
    exp_mem.push_back(32'h0010_001C);
    send_req(32'h0000_7000);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("ww_no_req", mem_req_valid, 0);
    chk("ww_busy", req_ready, 0);
    reset = 1'b1;
    step();
    chk_reset_outs("midreset");
    reset = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0009_9001;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (4) begin
      chk("stale_no_fill", mmu_update_valid, 0);
      chk("stale_no_resp", resp_valid, 0);
      chk("stale_idle", req_ready, 1);
      step();
    end

`ifdef TLB_MH_TIMEOUT_EN
    // Memory accepts but never responds: fault 16 cycles after WALK_REQ entry
    exp_mem.push_back(32'h0010_000C);
    exp_resp.push_back({32'h0000_0000, 1'b1});
    send_req(32'h0000_3000);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (14) step();
    chk("timeout_not_early", resp_valid, 0);
    step();
    chk("timeout_resp", resp_valid, 1);
    step();
    chk("timeout_idle", req_ready, 1);
`endif

    step();
    chk("resp_queue_drained", exp_resp.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("fill_queue_drained", exp_fill.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
